cgra_cfg_seq: RTL
=================

Name: cgra_cfg_seq

Overview:
- Parametrised CGRA configuration-memory block that replaces the fixed 64x16 single-read context memory.
- Adds a host load port and keeps the direct addressed read port.
- Adds a context sequencer that streams a programmable range of configuration words to NUM_CH PE-column channels, round-robin, with a valid/ready handshake.
- Sits between the host/loader and the PE array inside top.

Parameters:
DATA_W, 16, configuration word width
ADDR_W, 6, address width; DEPTH = 2**ADDR_W words
NUM_CH, 4, number of PE channels fed by the sequencer (>=1)
CH_W, $clog2(NUM_CH) (min 1), channel index width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
wr_en  in  1  host write strobe
wr_addr  in  ADDR_W  host write address
wr_data  in  DATA_W  host write data
rd_cm_en  in  1  direct read request
cm_addr  in  ADDR_W  direct read address
data_out  out  DATA_W  direct read data
data_out_vld  out  1  data_out valid, 1-cycle pulse
seq_start  in  1  start sequence, sampled in IDLE only
seq_base  in  ADDR_W  first word address
seq_len  in  ADDR_W+1  word count, 0..DEPTH
seq_loop  in  1  repeat the range until abort
seq_abort  in  1  terminate the sequence
seq_busy  out  1  sequencer not IDLE
seq_done  out  1  1-cycle pulse at normal completion
cfg_data  out  DATA_W  word to the PE channel
cfg_ch  out  CH_W  target channel index
cfg_valid  out  1  cfg_data/cfg_ch valid
cfg_ready  in  1  channel accepts the word

Behaviour:
- Reset (reset==0 at an edge):
  - State goes to IDLE.
  - data_out, data_out_vld, seq_busy, seq_done, cfg_data, cfg_ch and cfg_valid all go to 0.
  - Memory contents are not cleared and are retained across reset.
  - Reset mid-sequence drops cfg_valid at the next edge with no done pulse.
- Memory:
  - DEPTH x DATA_W with synchronous write and synchronous read.
  - Same-address read and write in the same cycle is read-first: the read returns the old word.
- Direct read:
  - rd_cm_en=1 at edge N gives data_out=mem[cm_addr] and data_out_vld=1 after edge N.
  - data_out holds its value when rd_cm_en=0; data_out_vld=0.
  - rd_cm_en is ignored while seq_busy=1.
- Sequencer FSM: IDLE, FETCH, SEND, DONE.
  - IDLE: on seq_start, latch base, len and loop, and set idx=0. Go to DONE if len==0, else FETCH. seq_start in any other state is ignored.
  - FETCH: issue read of (base+idx) mod DEPTH; ADDR_W arithmetic wraps naturally. Go to SEND.
  - SEND: cfg_valid=1, cfg_data=read word, cfg_ch=idx mod NUM_CH. The outputs are held stable until cfg_ready=1.
    - On handshake: idx++.
    - If idx was len-1 and loop=0: go to DONE.
    - If idx was len-1 and loop=1: idx=0, go to FETCH.
    - Otherwise: go to FETCH.
  - Throughput is 1 word per 2 cycles minimum.
  - DONE: seq_done=1 for exactly one cycle, then IDLE.
  - cfg_ch restarts at 0 on every loop iteration.
- seq_busy=1 in FETCH, SEND and DONE.
- seq_abort in FETCH or SEND:
  - Next state is IDLE, cfg_valid=0 after that edge, no seq_done.
  - An abort in the same cycle as a handshake counts as an accepted word, then IDLE.
  - seq_abort is ignored in IDLE and DONE.
- seq_len values above DEPTH wrap the read address and re-read the same words (legal).
- Host writes during a sequence are allowed. A word is read in FETCH, so a write to that address in the FETCH cycle is not seen.

Decomposition:
- Package cgra_cfg_pkg holds:
  - the state encoding (IDLE=2'd0, FETCH=2'd1, SEND=2'd2, DONE=2'd3);
  - default DATA_W, ADDR_W and NUM_CH constants;
  - a clog2 helper.
- One sub-module, cgra_cfg_mem: 1W/1R synchronous RAM, read-first, parametrised by DATA_W and ADDR_W.
  - The read address is muxed between the sequencer and cm_addr in the top-level block.

Test Plan:
- Direct read: load mem[k]=16'hA000+k for k=0..21, reset released. Pulse rd_cm_en with cm_addr=0..21 -> data_out=16'hA000+k one cycle later, data_out_vld pulses each read, data_out held after.
- Basic sequence, cfg_ready tied 1: seq_base=2, seq_len=6, loop=0 -> cfg_data A002..A007, cfg_ch 0,1,2,3,0,1, then one seq_done pulse; seq_busy low afterwards.
- Wrap and backpressure: seq_base=62, seq_len=4, cfg_ready low 3 cycles on word 2 -> addresses 62,63,0,1, cfg_data stable while stalled, no word dropped or duplicated.
- Loop and abort: seq_base=0, seq_len=3, loop=1 -> A000,A001,A002,A000,... with cfg_ch 0,1,2,0. seq_abort in SEND -> cfg_valid 0 next cycle, no seq_done.
- Zero length and ignored start: seq_len=0 -> seq_done one cycle after start, no cfg_valid. seq_start while busy ignored. rd_cm_en while busy gives no data_out_vld.
- Reset mid-sequence and read-first: reset low during SEND -> all outputs 0 next edge, memory intact on re-read. Same-cycle write 16'h5555/read of addr 5 -> old value returned.

Source files
------------

// File: rtl/cgra_cfg_pkg.sv
// Shared definitions for the CGRA configuration memory and context sequencer.
// Holds the state encoding, default geometry and a width helper.
package cgra_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 6;
    localparam int NUM_CH_DEF = 4;

    // Index width for 'value' items, never less than one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/cgra_cfg_mem.sv
// Single-write / single-read synchronous configuration RAM.
// A read and write to the same address in one cycle returns the old word.
module cgra_cfg_mem
    import cgra_cfg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // Contents are deliberately not reset so they survive a block reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cgra_cfg_seq.sv
// CGRA configuration memory with host load port, direct read port and a
// context sequencer streaming a word range round-robin to NUM_CH PE channels.
//
//   state | meaning
//   IDLE  | waiting for seq_start; direct reads allowed
//   FETCH | read of (base+idx) issued to the RAM
//   SEND  | word presented on cfg_*, held until cfg_ready
//   DONE  | one-cycle seq_done pulse, then IDLE
module cgra_cfg_seq
    import cgra_cfg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CH_W   = clog2_min1(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_cm_en,
    input  logic [ADDR_W-1:0] cm_addr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_vld,
    input  logic              seq_start,
    input  logic [ADDR_W-1:0] seq_base,
    input  logic [ADDR_W:0]   seq_len,
    input  logic              seq_loop,
    input  logic              seq_abort,
    output logic              seq_busy,
    output logic              seq_done,
    output logic [DATA_W-1:0] cfg_data,
    output logic [CH_W-1:0]   cfg_ch,
    output logic              cfg_valid,
    input  logic              cfg_ready
);

    seq_state_e        state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   idx_q;
    logic              loop_q;
    logic [CH_W-1:0]   ch_q;
    logic              cfg_valid_q;
    logic              seq_done_q;
    logic              seq_busy_q;
    logic              rd_vld_q;
    logic [DATA_W-1:0] hold_q;

    logic              direct_rd;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              last_word;
    logic [CH_W-1:0]   ch_next;

    assign direct_rd   = rd_cm_en && (state_q == ST_IDLE);
    assign mem_rd_en   = direct_rd || (state_q == ST_FETCH);
    assign mem_rd_addr = (state_q == ST_FETCH) ? (base_q + idx_q[ADDR_W-1:0]) : cm_addr;
    assign last_word   = (idx_q == (len_q - (ADDR_W+1)'(1)));
    assign ch_next     = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : (ch_q + CH_W'(1));

    cgra_cfg_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (mem_rd_en),
        .rd_addr_i (mem_rd_addr),
        .rd_data_o (mem_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            loop_q      <= 1'b0;
            ch_q        <= '0;
            cfg_valid_q <= 1'b0;
            seq_done_q  <= 1'b0;
            seq_busy_q  <= 1'b0;
        end else begin
            seq_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (seq_start) begin
                        base_q     <= seq_base;
                        len_q      <= seq_len;
                        loop_q     <= seq_loop;
                        idx_q      <= '0;
                        ch_q       <= '0;
                        seq_busy_q <= 1'b1;
                        if (seq_len == '0) begin
                            state_q    <= ST_DONE;
                            seq_done_q <= 1'b1;
                        end else begin
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (seq_abort) begin
                        state_q    <= ST_IDLE;
                        seq_busy_q <= 1'b0;
                    end else begin
                        state_q     <= ST_SEND;
                        cfg_valid_q <= 1'b1;
                    end
                end
                ST_SEND: begin
                    // An abort coinciding with a handshake still counts the word as taken.
                    if (cfg_ready) begin
                        cfg_valid_q <= 1'b0;
                        if (last_word) begin
                            idx_q <= '0;
                            ch_q  <= '0;
                        end else begin
                            idx_q <= idx_q + (ADDR_W+1)'(1);
                            ch_q  <= ch_next;
                        end
                        if (seq_abort) begin
                            state_q    <= ST_IDLE;
                            seq_busy_q <= 1'b0;
                        end else if (last_word && !loop_q) begin
                            state_q    <= ST_DONE;
                            seq_done_q <= 1'b1;
                        end else begin
                            state_q <= ST_FETCH;
                        end
                    end else if (seq_abort) begin
                        state_q     <= ST_IDLE;
                        cfg_valid_q <= 1'b0;
                        seq_busy_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    seq_busy_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // data_out tracks the RAM output only in the cycle after a direct read,
    // then falls back to a private copy so sequencer fetches cannot disturb it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_vld_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            rd_vld_q <= direct_rd;
            if (rd_vld_q) hold_q <= mem_rd_data;
        end
    end

    assign data_out     = rd_vld_q ? mem_rd_data : hold_q;
    assign data_out_vld = rd_vld_q;
    assign seq_busy     = seq_busy_q;
    assign seq_done     = seq_done_q;
    assign cfg_valid    = cfg_valid_q;
    assign cfg_ch       = ch_q;
    assign cfg_data     = cfg_valid_q ? mem_rd_data : '0;

endmodule
